// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts stalled bus cycles and flags expiry on the MAX_WAIT-th one
module mem_arb_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= i_clear ? '0 : i_count ? r_cnt + 1'b1 : r_cnt;
    end

    assign o_expired = i_count & (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and load/store;
// define MEM_TIMEOUT_EN to add the ack watchdog with sticky bus_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                instruction_ready,
    output logic [DATA_W-1:0]   instr_rdata,
    output logic                data_ready,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                bus_err
);

    state_t                r_state, w_next;
    logic                  r_instr_ready, r_data_ready, r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata, r_instr_rdata, r_dm_rdata;
    logic [DATA_W/8-1:0]   r_be;
    logic                  w_if_elig, w_dm_elig, w_done, w_timeout;
    logic                  w_grant_if, w_grant_dm;

    // A requester is stale while its ready pulse is high
    assign w_if_elig = if_req & ~r_instr_ready;
    assign w_dm_elig = dm_req & ~r_data_ready;
    assign w_done    = bus_ack | w_timeout;

    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_dm = w_dm_elig;
                w_grant_if = w_if_elig & ~w_dm_elig;
            end
            FETCH:   w_grant_dm = bus_ack & w_dm_elig;
            DATA:    w_grant_if = bus_ack & w_if_elig;
            default: ;
        endcase
        if (w_grant_dm)                    w_next = DATA;
        else if (w_grant_if)               w_next = FETCH;
        else if (r_state != IDLE && w_done) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_instr_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_instr_rdata <= '0;
            r_dm_rdata    <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
        end else begin
            r_state       <= w_next;
            r_instr_ready <= (r_state == FETCH) & w_done;
            r_data_ready  <= (r_state == DATA) & w_done;
            if (r_state == FETCH && w_done)
                r_instr_rdata <= bus_ack ? bus_rdata : DATA_W'(NOP_INSTR);
            if (r_state == DATA && w_done && !r_we)
                r_dm_rdata <= bus_ack ? bus_rdata : '0;
            if (w_grant_dm) begin
                r_we    <= dm_we;
                r_addr  <= dm_addr;
                r_wdata <= dm_we ? dm_wdata : '0;
                r_be    <= dm_we ? dm_be : '1;
            end else if (w_grant_if) begin
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_be    <= '1;
            end
        end
    end

    assign instruction_ready = r_instr_ready;
    assign data_ready        = r_data_ready;
    assign instr_rdata       = r_instr_rdata;
    assign dm_rdata          = r_dm_rdata;
    assign bus_req           = (r_state != IDLE);
    assign bus_we            = r_we;
    assign bus_addr          = r_addr;
    assign bus_wdata         = r_wdata;
    assign bus_be            = r_be;

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    mem_arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_grant_if | w_grant_dm),
        .i_count   (bus_req & ~bus_ack),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= r_err | w_timeout;
    end

    assign bus_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests with a scoreboard monitor for bus transactions and ready pulses
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        instruction_ready, data_ready, bus_req, bus_we, bus_err;
    logic [31:0] instr_rdata, dm_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int   n_vec = 0, n_err = 0;
    int   wait_cycles = 0, wcnt = 0;
    logic ack_off = 1'b0;

    bus_t        exp_bus[$];
    logic [31:0] exp_if[$], exp_dm[$];

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .instruction_ready(instruction_ready), .instr_rdata(instr_rdata),
        .data_ready(data_ready), .dm_rdata(dm_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic bus_t mk(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_t t;
        t.we = we; t.addr = a; t.wdata = d; t.be = be;
        return t;
    endfunction

    // Bus slave: acks after wait_cycles stalled cycles, data derived from the address
    initial begin
        forever begin
            @(negedge clk);
            if (bus_req && !ack_off && wcnt >= wait_cycles) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata_of(bus_addr);
                wcnt      = 0;
            end else begin
                bus_ack = 1'b0;
                wcnt    = (bus_req && !ack_off) ? wcnt + 1 : 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        bus_t e;
        forever begin
            step();
            if (bus_req && bus_ack) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", {31'd0, bus_req}, 64'd0);
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_we", bus_we, e.we);
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_wdata", bus_wdata, e.wdata);
                    chk("bus_be", bus_be, e.be);
                end
            end
            if (instruction_ready) begin
                if (exp_if.size() == 0) chk("if_unexpected", instr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("instr_rdata", instr_rdata, exp_if.pop_front());
            end
            if (data_ready) begin
                if (exp_dm.size() == 0) chk("dm_unexpected", dm_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
            end
        end
    end

    initial begin
        int nir, ndr;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_ready", {instruction_ready, data_ready}, 0);
        chk("rst_rdata", {instr_rdata, dm_rdata}, 0);
        chk("rst_bus_fields", {bus_we, bus_be, bus_addr}, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_err", bus_err, 0);

        // Fetch only, zero-wait bus
        if_req = 1'b1; if_addr = 32'h100;
        exp_bus.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF));
        exp_if.push_back(rdata_of(32'h100));
        step();
        chk("f1_bus_req", bus_req, 1);
        chk("f1_bus_addr", bus_addr, 32'h100);
        chk("f1_no_ready_yet", instruction_ready, 0);
        step();
        chk("f1_ready", instruction_ready, 1);
        if_req = 1'b0;
        step();
        chk("f1_idle", {bus_req, instruction_ready}, 0);

        // Simultaneous requests: data first, fetch follows without a gap
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        exp_bus.push_back(mk(1'b0, 32'h2000, 32'h0, 4'hF));
        exp_bus.push_back(mk(1'b0, 32'h200, 32'h0, 4'hF));
        exp_dm.push_back(rdata_of(32'h2000));
        exp_if.push_back(rdata_of(32'h200));
        step();
        chk("s2_data_first", bus_addr, 32'h2000);
        step();
        chk("s2_data_ready", data_ready, 1);
        chk("s2_no_gap", bus_req, 1);
        chk("s2_fetch_addr", bus_addr, 32'h200);
        dm_req = 1'b0;
        step();
        chk("s2_instr_ready", instruction_ready, 1);
        chk("s2_idle", bus_req, 0);
        if_req = 1'b0;
        step();

        // Store with 3 wait cycles; requester fields change after grant
        wait_cycles = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        exp_bus.push_back(mk(1'b1, 32'h3000, 32'hDEADBEEF, 4'b0011));
        exp_dm.push_back(rdata_of(32'h2000));
        for (int i = 0; i < 4; i++) begin
            step();
            dm_wdata = 32'h1234_5678; dm_be = 4'b1100;
            chk("st_bus_req", bus_req, 1);
            chk("st_fields", {bus_we, bus_be, bus_addr}, {1'b1, 4'b0011, 32'h3000});
            chk("st_wdata", bus_wdata, 32'hDEADBEEF);
            chk("st_no_ready", data_ready, 0);
        end
        step();
        chk("st_data_ready", data_ready, 1);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        chk("st_idle", bus_req, 0);
        wait_cycles = 0;

        // Continuous data requests with a pending fetch: grants alternate
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_addr = 32'h5000;
        for (int k = 0; k < 3; k++) begin
            exp_bus.push_back(mk(1'b0, 32'h5000 + 32'(4 * k), 32'h0, 4'hF));
            exp_bus.push_back(mk(1'b0, 32'h400 + 32'(4 * k), 32'h0, 4'hF));
            exp_dm.push_back(rdata_of(32'h5000 + 32'(4 * k)));
            exp_if.push_back(rdata_of(32'h400 + 32'(4 * k)));
        end
        nir = 0; ndr = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (data_ready) begin ndr++; dm_addr = dm_addr + 4; end
            if (instruction_ready) begin nir++; if_addr = if_addr + 4; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("alt_fetch_count", nir, 3);
        chk("alt_data_count", ndr, 3);
        step();
        chk("alt_idle", bus_req, 0);

        // Reset while a fetch is outstanding
        ack_off = 1'b1;
        if_req = 1'b1; if_addr = 32'h600;
        step();
        chk("rs_bus_req", bus_req, 1);
        step();
        #1 rst_n = 1'b0;
        #1 chk("rs_async_drop", bus_req, 0);
        chk("rs_bus_addr", bus_addr, 0);
        step();
        chk("rs_no_ready", instruction_ready, 0);
        if_req = 1'b0; rst_n = 1'b1; ack_off = 1'b0;
        step();
        chk("rs_idle", {bus_req, instruction_ready}, 0);
        chk("rs_rdata_clr", instr_rdata, 0);
        if_req = 1'b1; if_addr = 32'h700;
        exp_bus.push_back(mk(1'b0, 32'h700, 32'h0, 4'hF));
        exp_if.push_back(rdata_of(32'h700));
        step();
        chk("rs_refetch", {bus_req, bus_addr}, {1'b1, 32'h700});
        step();
        chk("rs_ready", instruction_ready, 1);
        if_req = 1'b0;
        step();

`ifdef MEM_TIMEOUT_EN
        // Fetch never acked: abort after 15 stalled cycles with NOP
        ack_off = 1'b1;
        if_req = 1'b1; if_addr = 32'h800;
        exp_if.push_back(32'h0000_0013);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_bus_req", bus_req, 1);
            chk("to_no_err_yet", bus_err, 0);
        end
        step();
        chk("to_ready", instruction_ready, 1);
        chk("to_err", bus_err, 1);
        chk("to_abort_idle", bus_req, 0);
        if_req = 1'b0; ack_off = 1'b0;
        step();
        chk("to_err_sticky", bus_err, 1);
`else
        chk("no_timeout_err", bus_err, 0);
`endif

        repeat (2) step();
        chk("bus_q_drained", exp_bus.size(), 0);
        chk("if_q_drained", exp_if.size(), 0);
        chk("dm_q_drained", exp_dm.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
